// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder/subtractor. Each stage adds one STAGE_W-bit chunk and hands
// its carry, the partial sum and the still-unprocessed operand bits to the next stage.
// A single advance enable freezes the whole pipe while the output is stalled.
module adder_pipe #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned STAGE_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / STAGE_W;

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added, starting at chunk k.
        localparam int unsigned InW = WIDTH - k * STAGE_W;

        logic [InW-1:0]     in_a;
        logic [InW-1:0]     in_b;
        logic [WIDTH-1:0]   s_in;
        logic               cin;
        logic               vin;
        logic [STAGE_W-1:0] chunk;
        logic               cy_d;
        logic [WIDTH-1:0]   s_d;
        logic [WIDTH-1:0]   s_q;
        logic               cy_q;
        logic               vld_q;

        if (k == 0) begin : g_src
            // Subtraction is a + ~b + 1; c_in is ignored in that mode.
            assign in_a = a;
            assign in_b = sub ? ~b : b;
            assign cin  = sub ? 1'b1 : c_in;
            assign vin  = in_valid;
            assign s_in = '0;
        end else begin : g_src
            assign in_a = g_stage[k-1].g_pass.ra_q;
            assign in_b = g_stage[k-1].g_pass.rb_q;
            assign cin  = g_stage[k-1].cy_q;
            assign vin  = g_stage[k-1].vld_q;
            assign s_in = g_stage[k-1].s_q;
        end

        // Add this stage's chunk and merge it into the partial sum.
        always_comb begin
            {cy_d, chunk} = {1'b0, in_a[STAGE_W-1:0]} + {1'b0, in_b[STAGE_W-1:0]}
                          + {{STAGE_W{1'b0}}, cin};
            s_d = s_in;
            s_d[k*STAGE_W +: STAGE_W] = chunk;
        end

        // Stage register: valid moves on every advance, data only with a real op.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                s_q   <= '0;
                cy_q  <= 1'b0;
            end else if (adv) begin
                vld_q <= vin;
                if (vin) begin
                    s_q  <= s_d;
                    cy_q <= cy_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_pass
            logic [InW-STAGE_W-1:0] ra_q;
            logic [InW-STAGE_W-1:0] rb_q;

            // Forward only the operand bits later stages still need.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else if (adv && vin) begin
                    ra_q <= in_a[InW-1:STAGE_W];
                    rb_q <= in_b[InW-1:STAGE_W];
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
            assign ovf_d = cy_d ^ (in_a[InW-1] ^ in_b[InW-1] ^ chunk[STAGE_W-1]);

            // Overflow flag registered alongside the final sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv && vin) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign c_out     = g_stage[STAGES-1].cy_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
